wide_add_seq: RTL and testbench
===============================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter W, default 256, total operand width.
REQ-002 SHALL have parameter N, default 32, slice width added per cycle; W SHALL be an integer multiple of N, with W/N >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  first operand, unsigned.
REQ-008 b  input  W  second operand, unsigned.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  W+1  registered result; bit W is carry-out.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; transfer on in_valid&&in_ready latches a, b, sets slice index k=0 and carry=0, then goes to RUN.
REQ-015 RUN: each cycle SHALL compute {c,s} = a[k] + b[k] + carry over N-bit slice k, write s to sum slice k, set carry=c, and increment k.
REQ-016 On the last slice (k=W/N-1), the final carry SHALL be written to sum[W] and the FSM SHALL go to DONE.
REQ-017 out_valid SHALL be high exactly in DONE, first asserted W/N cycles after the accepting edge.
REQ-018 DONE: sum and out_valid SHALL hold stable until out_ready=1, then the FSM goes to IDLE; there is no transfer in the same cycle.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored there.
REQ-020 Operand inputs SHALL be sampled only on the accepting edge; later changes to a or b SHALL have no effect.
REQ-021 sum SHALL equal (a+b) mod 2^(W+1) exactly, including a full carry ripple across all slices.

Reset
REQ-022 rst SHALL force the following: FSM to IDLE, k=0, carry=0, sum=0, out_valid=0, busy=0, in_ready=1 on the next edge.
REQ-023 rst in RUN or DONE SHALL discard the operation; no out_valid pulse SHALL follow.
REQ-024 rst SHALL dominate in_valid and out_ready in the same cycle.

Configuration
REQ-025 Macro WIDE_ADD_SEQ_SUB_EN defined: input port sub (1 bit) SHALL be sampled with the operands.
- When sub=1, the block computes a + ~b + 1 (initial carry=1, b inverted per slice).
- sum[W] = 1 means no borrow.
REQ-026 Macro undefined: port sub SHALL be absent and the block SHALL only add.

Structure
REQ-027 Package wide_add_pkg SHALL hold the FSM state enum typedef and the slice-count constant function.
REQ-028 Sub-module cla_slice SHALL be a combinational N-bit carry look-ahead adder with carry-in, producing N-bit sum and carry-out.
REQ-029 wide_add_seq SHALL instantiate exactly one cla_slice, time-multiplexed across slices.

Verification (W=12, N=3)
REQ-030 a=0x000, b=0x001 -> out_valid 4 cycles after acceptance, sum=0x0001.
REQ-031 a=0xFFF, b=0x001 -> sum=0x1000, with carry rippled through all 4 slices.
REQ-032 a=0xFFF, b=0xFFF -> sum=0x1FFE; then a=0x5A5, b=0x0F0 back-to-back -> sum=0x0695.
REQ-033 out_ready held low for 5 cycles in DONE -> sum and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034 rst asserted while k=2 -> next cycle out_valid=0, sum=0, in_ready=1, and no result is emitted.
REQ-035 With WIDE_ADD_SEQ_SUB_EN: a=0x005, b=0x007, sub=1 -> sum=0x0FFE (borrow); a=0x007, b=0x005 -> sum=0x1002.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the sequential wide adder (wide_add_seq).
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int slice_count(input int w, input int n);
    return w / n;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational N-bit carry look-ahead adder with carry-in and carry-out.
module cla_slice #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         pr;

  assign g = x & y;
  assign p = x ^ y;

  // Each carry is a flat sum of products over lower generate/propagate terms.
  always_comb begin
    c    = '0;
    pr   = 1'b1;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      pr = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pr & g[j]);
        pr     = pr & p[j];
      end
      c[i+1] = c[i+1] | (pr & cin);
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/wide_add_seq.sv
// Sequential W-bit adder: one N-bit CLA slice reused over W/N cycles.
// Optional subtract mode (port sub) is enabled by defining WIDE_ADD_SEQ_SUB_EN.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int W = 256,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef WIDE_ADD_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum,
  output logic         busy,
  output state_t       state
);

  localparam int SLICES = slice_count(W, N);
  localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t         state_next;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [KW-1:0]  k;
  logic           carry;
  logic           accept;
  logic           last;
  logic           sub_in;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [N-1:0]   slice_sum;
  logic           slice_cout;

`ifdef WIDE_ADD_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign accept = in_valid && (state == IDLE);
  assign last   = (k == KW'(SLICES - 1));
  assign op_a   = a_q[int'(k)*N +: N];
  assign op_b   = b_q[int'(k)*N +: N];

  cla_slice #(.N(N)) u_cla (
    .x    (op_a),
    .y    (op_b),
    .cin  (carry),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction stores ~b and seeds carry=1, so the slice loop is identical.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      k     <= '0;
      carry <= 1'b0;
      sum   <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub_in ? ~b : b;
      k     <= '0;
      carry <= sub_in;
    end else if (state == RUN) begin
      sum[int'(k)*N +: N] <= slice_sum;
      carry               <= slice_cout;
      k                   <= k + 1'b1;
      if (last) begin
        sum[W] <= slice_cout;
        k      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq at W=12, N=3 (sub tests when WIDE_ADD_SEQ_SUB_EN is defined).
module tb_wide_add_seq;
  import wide_add_pkg::*;

  localparam int W      = 12;
  localparam int N      = 3;
  localparam int WP     = W + 1;
  localparam int SLICES = W / N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    sum;
  logic          busy;
  state_t        state;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  wide_add_seq #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef WIDE_ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy),
    .state     (state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] yy;
    yy = s ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + WP'(s);
  endfunction

  // Scoreboard: a result is consumed on any edge where out_valid && out_ready.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else                   check("sum", sum, exp_q.pop_front());
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic [W:0] exp, input int hold);
    int lat;
    check("in_ready_idle", in_ready, 1);
    check("busy_idle", busy, 0);
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check("in_ready_run", in_ready, 0);
    check("busy_run", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, SLICES);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, exp);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           seen;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 12'hABC; b = 12'h123; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_state", state, IDLE);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    run_op(12'h000, 12'h001, 1'b0, 13'h0001, 0);
    run_op(12'hFFF, 12'h001, 1'b0, 13'h1000, 0);
    run_op(12'hFFF, 12'hFFF, 1'b0, 13'h1FFE, 0);
    run_op(12'h5A5, 12'h0F0, 1'b0, 13'h0695, 0);
    run_op(12'h123, 12'h456, 1'b0, 13'h0579, 5);
`ifdef WIDE_ADD_SEQ_SUB_EN
    run_op(12'h005, 12'h007, 1'b1, 13'h0FFE, 0);
    run_op(12'h007, 12'h005, 1'b1, 13'h1002, 2);
`endif

    // Abort mid-operation at k=2: nothing may be emitted afterwards.
    a = 12'h777; b = 12'h111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_out", seen, 0);
    out_ready = 1'b0;

    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef WIDE_ADD_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, model(ra, rb, rs), $urandom_range(0, 3));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
